// File: rtl/sha1_pkg.sv
// sha1_pkg: shared types, constants and helpers for the SHA-1 message schedule.
//   word_t         - 32-bit message/schedule word
//   SHA1_ROUNDS    - number of schedule words emitted per block (80)
//   SHA1_BLK_WORDS - number of message words loaded per block (16)
//   sched_state_t  - schedule FSM state {LOAD, EMIT}
//   rotl1()        - rotate a word left by one bit
package sha1_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned SHA1_ROUNDS    = 80;
    localparam int unsigned SHA1_BLK_WORDS = 16;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } sched_state_t;

    function automatic word_t rotl1(input word_t x);
        return {x[30:0], x[31]};
    endfunction

endpackage

// File: rtl/msg_window.sv
// msg_window: 16 x 32-bit register window holding the sliding schedule state.
// Contents are deliberately not reset.
// Ports:
//   clk            - clock
//   we             - write enable
//   waddr, wdata   - write port
//   raddr0..raddr3 - four combinational read addresses
//   rdata0..rdata3 - four combinational read data outputs
module msg_window
    import sha1_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [3:0] waddr,
    input  word_t      wdata,
    input  logic [3:0] raddr0,
    input  logic [3:0] raddr1,
    input  logic [3:0] raddr2,
    input  logic [3:0] raddr3,
    output word_t      rdata0,
    output word_t      rdata1,
    output word_t      rdata2,
    output word_t      rdata3
);

    word_t mem [SHA1_BLK_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata0 = mem[raddr0];
        rdata1 = mem[raddr1];
        rdata2 = mem[raddr2];
        rdata3 = mem[raddr3];
    end

endmodule

// File: rtl/msg_schedule.sv
// msg_schedule: SHA-1 message schedule generator.
// Loads 16 big-endian message words (W0 first), then emits W0..W79 one per
// handshake, expanding W16..W79 in place in a 16-word sliding window.
// Optional feature: define MSG_SCHED_CNT_EN to add the saturating blk_cnt output.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid, in_ready   - message word input handshake
//   in_word              - message word
//   w_valid, w_ready     - schedule word output handshake
//   w_data, w_idx        - schedule word W[w_idx], w_idx in 0..79
//   sched_done           - one-cycle pulse after W79 is consumed
//   busy                 - high while emitting
//   blk_cnt              - completed-block count (MSG_SCHED_CNT_EN only)
module msg_schedule
    import sha1_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_data,
    output logic [6:0]  w_idx,
    output logic        sched_done,
    output logic        busy
`ifdef MSG_SCHED_CNT_EN
    ,
    output logic [15:0] blk_cnt
`endif
);

    localparam logic [6:0] LAST_T     = 7'(SHA1_ROUNDS - 1);
    localparam logic [6:0] FIRST_EXP  = 7'(SHA1_BLK_WORDS);
    localparam logic [3:0] LAST_LD    = 4'(SHA1_BLK_WORDS - 1);

    sched_state_t state_q, state_d;
    logic [3:0]   ld_cnt_q;
    logic [6:0]   t_q;
    logic         sched_done_q;

    logic  accept;
    logic  w_hs;
    logic  last_hs;

    logic       win_we;
    logic [3:0] win_waddr;
    word_t      win_wdata;
    logic [3:0] ra_m3, ra_m8, ra_m14, ra_t;
    word_t      rd_m3, rd_m8, rd_m14, rd_t;

    assign accept  = in_valid && (state_q == LOAD);
    assign w_hs    = w_ready && (state_q == EMIT);
    assign last_hs = w_hs && (t_q == LAST_T);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD: if (accept && (ld_cnt_q == LAST_LD)) state_d = EMIT;
            EMIT: if (last_hs)                         state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready   = (state_q == LOAD);
        w_valid    = (state_q == EMIT);
        busy       = (state_q == EMIT);
        w_idx      = t_q;
        sched_done = sched_done_q;
    end

    // ---------------------------------------------------------------------
    // Counters and done pulse
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_cnt_q     <= '0;
            t_q          <= '0;
            sched_done_q <= 1'b0;
        end else begin
            sched_done_q <= last_hs;
            if (accept) begin
                // Wraps to 0 on the 16th word, ready for the next block.
                ld_cnt_q <= ld_cnt_q + 4'd1;
            end else if (last_hs) begin
                ld_cnt_q <= '0;
            end
            if (w_hs) begin
                t_q <= last_hs ? 7'd0 : t_q + 7'd1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Window and expansion
    // ---------------------------------------------------------------------
    // Slot t&15 still holds W[t-16] until it is overwritten with W[t].
    always_comb begin
        ra_t   = t_q[3:0];
        ra_m3  = t_q[3:0] + 4'd13;
        ra_m8  = t_q[3:0] + 4'd8;
        ra_m14 = t_q[3:0] + 4'd2;
    end

    always_comb begin
        if (t_q < FIRST_EXP) begin
            w_data = rd_t;
        end else begin
            w_data = rotl1(rd_m3 ^ rd_m8 ^ rd_m14 ^ rd_t);
        end
    end

    always_comb begin
        win_we    = 1'b0;
        win_waddr = ld_cnt_q;
        win_wdata = in_word;
        if (!rst) begin
            if (accept) begin
                win_we = 1'b1;
            end else if (w_hs && (t_q >= FIRST_EXP)) begin
                win_we    = 1'b1;
                win_waddr = t_q[3:0];
                win_wdata = w_data;
            end
        end
    end

    msg_window u_window (
        .clk    (clk),
        .we     (win_we),
        .waddr  (win_waddr),
        .wdata  (win_wdata),
        .raddr0 (ra_m3),
        .raddr1 (ra_m8),
        .raddr2 (ra_m14),
        .raddr3 (ra_t),
        .rdata0 (rd_m3),
        .rdata1 (rd_m8),
        .rdata2 (rd_m14),
        .rdata3 (rd_t)
    );

`ifdef MSG_SCHED_CNT_EN
    // ---------------------------------------------------------------------
    // Saturating completed-block counter
    // ---------------------------------------------------------------------
    logic [15:0] blk_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_q <= '0;
        end else if (sched_done_q && (blk_cnt_q != 16'hFFFF)) begin
            blk_cnt_q <= blk_cnt_q + 16'd1;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_msg_schedule.sv
module tb_msg_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [6:0]  w_idx;
    logic        sched_done;
    logic        busy;
`ifdef MSG_SCHED_CNT_EN
    logic [15:0] blk_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] blk_words [16];
    logic [31:0] exp_w     [80];
    logic [31:0] got_w     [80];

    always #5 clk = ~clk;

    msg_schedule dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .w_idx      (w_idx),
        .sched_done (sched_done),
        .busy       (busy)
`ifdef MSG_SCHED_CNT_EN
        ,
        .blk_cnt    (blk_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Textbook SHA-1 expansion over a plain array.
    task automatic build_model();
        logic [31:0] x;
        for (int t = 0; t < 16; t++) exp_w[t] = blk_words[t];
        for (int t = 16; t < 80; t++) begin
            x = exp_w[t-3] ^ exp_w[t-8] ^ exp_w[t-14] ^ exp_w[t-16];
            exp_w[t] = {x[30:0], x[31]};
        end
    endtask

    task automatic rand_block();
        for (int i = 0; i < 16; i++) blk_words[i] = $urandom;
        build_model();
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; w_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic load_block();
        int k = 0;
        int cyc = 0;
        while (k < 16 && cyc < 200) begin
            in_valid = 1'b1;
            in_word  = blk_words[k];
            if (in_ready) k++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        in_word  = $urandom;
        total++;
        if (k != 16 || w_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL load_enter_emit: accepted=%0d w_valid=%b in_ready=%b, want 16 1 0",
                     k, w_valid, in_ready);
        end
    endtask

    // Consume all 80 words; rnd selects random backpressure.
    task automatic drain(input bit rnd);
        int k = 0;
        int cyc = 0;
        int early_dones = 0;
        bit stalled = 1'b0;
        logic [31:0] last_d;
        logic [6:0]  last_i;
        while (k < 80 && cyc < 2000) begin
            w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sched_done) early_dones++;
            if (w_valid !== 1'b1 || busy !== 1'b1) begin
                total++; bad++;
                $display("FAIL drain_valid: k=%0d w_valid=%b busy=%b, want 1 1", k, w_valid, busy);
                break;
            end
            if (stalled) begin
                total++;
                if (w_data !== last_d || w_idx !== last_i) begin
                    bad++;
                    $display("FAIL stall_stable: idx=%0d data=%h, want idx=%0d data=%h",
                             w_idx, w_data, last_i, last_d);
                end
            end
            total++;
            if (w_idx !== 7'(k) || w_data !== exp_w[k]) begin
                bad++;
                $display("FAIL word: idx=%0d data=%h, want idx=%0d data=%h",
                         w_idx, w_data, k, exp_w[k]);
            end
            got_w[k] = w_data;
            stalled  = !w_ready;
            last_d   = w_data;
            last_i   = w_idx;
            if (w_ready) k++;
            step();
            cyc++;
        end
        w_ready = 1'b0;
        total++;
        if (k != 80) begin
            bad++;
            $display("FAIL drain_bound: consumed=%0d, want 80", k);
        end
        if (!rnd) begin
            total++;
            if (cyc != 80) begin
                bad++;
                $display("FAIL throughput: cycles=%0d, want 80", cyc);
            end
        end
        total++;
        if (early_dones != 0 || sched_done !== 1'b1 || in_ready !== 1'b1 || w_valid !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: early=%0d done=%b in_ready=%b w_valid=%b, want 0 1 1 0",
                     early_dones, sched_done, in_ready, w_valid);
        end
        step();
        total++;
        if (sched_done !== 1'b0) begin
            bad++;
            $display("FAIL done_width: sched_done=%b, want 0", sched_done);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (in_ready !== 1'b1 || w_valid !== 1'b0 || busy !== 1'b0 || sched_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: in_ready=%b w_valid=%b busy=%b done=%b, want 1 0 0 0",
                     in_ready, w_valid, busy, sched_done);
        end
`ifdef MSG_SCHED_CNT_EN
        total++;
        if (blk_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_cnt: blk_cnt=%h, want 0000", blk_cnt);
        end
`endif
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk_words[i] = 32'h0;
        blk_words[0]  = 32'h61626380;
        blk_words[15] = 32'h00000018;
        build_model();
    endtask

    task automatic test_abc();
        do_reset();
        set_abc();
        load_block();
        drain(1'b0);
        total++;
        if (got_w[0] !== 32'h61626380 || got_w[15] !== 32'h00000018 || got_w[16] !== 32'hC2C4C700)
        begin
            bad++;
            $display("FAIL abc_known: W0=%h W15=%h W16=%h, want 61626380 00000018 c2c4c700",
                     got_w[0], got_w[15], got_w[16]);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_abc();
        load_block();
        drain(1'b1);
    endtask

    task automatic test_random_blocks();
        do_reset();
        for (int b = 0; b < 3; b++) begin
            rand_block();
            load_block();
            drain(b == 1);
        end
    endtask

    task automatic test_reset_mid_emit();
        int cyc = 0;
        do_reset();
        rand_block();
        load_block();
        w_ready = 1'b1;
        while (w_idx != 7'd40 && cyc < 200) begin
            step();
            cyc++;
        end
        rst = 1'b1; // coincides with a handshake at t=40
        step();
        rst = 1'b0;
        w_ready = 1'b0;
        total++;
        if (w_valid !== 1'b0 || sched_done !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_emit: w_valid=%b done=%b in_ready=%b busy=%b, want 0 0 1 0",
                     w_valid, sched_done, in_ready, busy);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (sched_done !== 1'b0 || w_valid !== 1'b0) begin
                bad++;
                $display("FAIL rst_emit_idle: done=%b w_valid=%b, want 0 0", sched_done, w_valid);
            end
        end
        rand_block();
        load_block();
        drain(1'b0);
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_word  = $urandom;
            step();
        end
        rst = 1'b1;
        in_word = $urandom;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        rand_block();
        load_block();
        drain(1'b0);
    endtask

    // in_valid held high with a fresh word every cycle and w_ready held high:
    // block 1 loads in cycles 0..15, emits 16..95, block 2 loads 96..111.
    task automatic test_back_to_back();
        logic [31:0] stream [193];
        bit ein, ev, edone;
        int idx;
        do_reset();
        for (int c = 0; c <= 192; c++) begin
            stream[c] = $urandom;
            in_word   = stream[c];
            in_valid  = (c != 192);
            w_ready   = 1'b1;
            if (c == 16 || c == 112) begin
                for (int i = 0; i < 16; i++) blk_words[i] = stream[c - 16 + i];
                build_model();
            end
            ein   = (c < 16) || (c >= 96 && c < 112) || (c >= 192);
            ev    = (c >= 16 && c < 96) || (c >= 112 && c < 192);
            edone = (c == 96) || (c == 192);
            total++;
            if (in_ready !== ein || w_valid !== ev || sched_done !== edone) begin
                bad++;
                $display("FAIL b2b_ctrl: c=%0d in_ready=%b w_valid=%b done=%b, want %b %b %b",
                         c, in_ready, w_valid, sched_done, ein, ev, edone);
            end
            if (ev) begin
                idx = (c < 96) ? c - 16 : c - 112;
                total++;
                if (w_idx !== 7'(idx) || w_data !== exp_w[idx]) begin
                    bad++;
                    $display("FAIL b2b_word: c=%0d idx=%0d data=%h, want idx=%0d data=%h",
                             c, w_idx, w_data, idx, exp_w[idx]);
                end
            end
            if (c != 192) step();
        end
        in_valid = 1'b0;
        w_ready  = 1'b0;
    endtask

`ifdef MSG_SCHED_CNT_EN
    task automatic test_cnt();
        do_reset();
        for (int b = 0; b < 3; b++) begin
            rand_block();
            load_block();
            drain(1'b0);
        end
        total++;
        if (blk_cnt !== 16'd3) begin
            bad++;
            $display("FAIL cnt_three: blk_cnt=%h, want 0003", blk_cnt);
        end
        force dut.blk_cnt_q = 16'hFFFF;
        step();
        release dut.blk_cnt_q;
        rand_block();
        load_block();
        drain(1'b0);
        total++;
        if (blk_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL cnt_sat: blk_cnt=%h, want ffff", blk_cnt);
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_word  = 32'h0;
        w_ready  = 1'b0;
        step();
        step();
        test_reset();
        test_abc();
        test_backpressure();
        test_random_blocks();
        test_reset_mid_emit();
        test_reset_mid_load();
        test_back_to_back();
`ifdef MSG_SCHED_CNT_EN
        test_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msg_schedule.md
MSG_SCHEDULE -- requirements
Module: msg_schedule

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: in_word carries a valid message word.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-005 SHALL have port in_word, input, 32 bits: message word, big-endian, first accepted word = W0.
REQ-006 SHALL have port w_valid, output, 1 bit: w_data/w_idx carry a valid schedule word.
REQ-007 SHALL have port w_ready, input, 1 bit: rounds stage consumes the word this cycle.
REQ-008 SHALL have port w_data, output, 32 bits: schedule word W[w_idx].
REQ-009 SHALL have port w_idx, output, 7 bits: round index 0..79.
REQ-010 SHALL have port sched_done, output, 1 bit: one-cycle pulse after W79 is consumed.
REQ-011 SHALL have port busy, output, 1 bit: high in EMIT state.
REQ-012 SHALL have port blk_cnt, output, 16 bits: completed-block count; present only with MSG_SCHED_CNT_EN.

Function
REQ-013 SHALL implement two states, LOAD and EMIT; in_ready = (state==LOAD), w_valid = busy = (state==EMIT).
REQ-014 In LOAD, each in_valid&&in_ready cycle SHALL write in_word to window slot ld_cnt (0..15) and increment ld_cnt.
REQ-015 On acceptance of the 16th word, the block SHALL enter EMIT with t=0; w_valid rises the following cycle.
REQ-016 In EMIT, w_idx SHALL equal t; for t<16, w_data = win[t].
REQ-017 For t>=16, w_data SHALL equal rotl1(win[(t-3)&15] ^ win[(t-8)&15] ^ win[(t-14)&15] ^ win[t&15]), computed combinationally from the registered window.
REQ-018 On each w_valid&&w_ready with t>=16, the block SHALL write w_data into win[t&15]; t SHALL increment on every handshake.
REQ-019 With w_valid high and w_ready low, w_data and w_idx SHALL hold stable, with no state change.
REQ-020 On the handshake at t=79, the block SHALL pulse sched_done for exactly the next cycle, return to LOAD, and clear ld_cnt; in_ready is high in that same cycle.
REQ-021 Throughput SHALL be one word per cycle when w_ready is held high: 80 EMIT cycles per block, 96 cycles minimum per block.
REQ-022 in_valid during EMIT SHALL be ignored, with nothing stored.
REQ-023 All arithmetic SHALL be 32-bit XOR/rotate only, with no carries; index math SHALL be modulo 16.

Reset
REQ-024 rst SHALL force: state=LOAD, ld_cnt=0, t=0, sched_done=0, blk_cnt=0; in_ready=1, w_valid=0, busy=0 on the following cycle.
REQ-025 Window contents SHALL NOT be reset; they are don't-care until reloaded.
REQ-026 rst mid-LOAD or mid-EMIT SHALL discard the partial block, with no sched_done pulse.
REQ-027 rst SHALL take priority over simultaneous handshakes in the same cycle.

Configuration
REQ-028 With MSG_SCHED_CNT_EN defined, blk_cnt SHALL increment on each sched_done pulse and saturate at 16'hFFFF.
REQ-029 Without MSG_SCHED_CNT_EN, the blk_cnt port and counter logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 A shared package sha1_pkg SHALL hold: word_t (32-bit), SHA1_ROUNDS=80, SHA1_BLK_WORDS=16, state enum {LOAD, EMIT}, and the function rotl1.
REQ-031 A sub-module msg_window SHALL implement the 16x32 register window, with one write port and four combinational read ports.

Verification
REQ-032 SHALL cover "abc" block: W0=0x61626380, W1..W14=0, W15=0x00000018 -> W0..W15 echoed, W16=0xC2C4C700, and all 80 words match the software model.
REQ-033 SHALL cover backpressure: w_ready toggled randomly -> w_data/w_idx stable while stalled, the same 80-word sequence as REQ-032, and exactly one sched_done.
REQ-034 SHALL cover reset mid-EMIT: rst at t=40 -> w_valid=0 next cycle, no sched_done, in_ready=1, and a fresh block then produces correct W0..W79.
REQ-035 SHALL cover back-to-back blocks: in_valid held high across 2 blocks -> words offered during EMIT are ignored, and the second block loads starting in the sched_done cycle.
REQ-036 SHALL cover MSG_SCHED_CNT_EN: 3 blocks -> blk_cnt=3, and a forced 16'hFFFF + 1 block -> stays 16'hFFFF.
REQ-037 SHALL cover reset mid-LOAD: rst after 7 words -> the next 16 accepted words form W0..W15.
